// File: rtl/sd_host_pkg.sv
// Shared SD host types: command-sequencer state encoding, response-type codes,
// the latched command request and the default response timeout.
package sd_host_pkg;

    localparam int unsigned CMD_INDEX_W            = 6;
    localparam int unsigned RESP_TYPE_W            = 2;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;
    localparam int unsigned DEFAULT_CNT_W          = 11;

    typedef logic [RESP_TYPE_W-1:0] resp_type_t;

    localparam resp_type_t RESP_NONE = 2'b00;
    localparam resp_type_t RESP_136  = 2'b01;
    localparam resp_type_t RESP_48   = 2'b10;
    localparam resp_type_t RESP_48B  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_RESP,
        STORE_RESP,
        WAIT_BUSY,
        SIGNAL,
        ERROR
    } seq_state_e;

    typedef struct packed {
        logic [CMD_INDEX_W-1:0] index;
        resp_type_t             resp_type;
        logic                   data_present;
    } cmd_req_t;

    // True when the command returns a response that must be stored.
    function automatic logic resp_expected(resp_type_t rt);
        case (rt)
            RESP_NONE:                   return 1'b0;
            RESP_136, RESP_48, RESP_48B: return 1'b1;
            default:                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sd_cmd_sequencer_if.sv
// Host-register and CMD-engine signals around the command sequencer.
// master = sequencer side, slave = register file / CMD engine side.
interface sd_cmd_sequencer_if;
    import sd_host_pkg::*;

    logic                   cmd_write;
    logic [CMD_INDEX_W-1:0] cmd_index_in;
    resp_type_t             resp_type_in;
    logic                   data_present_in;
    logic                   timeout_enable;
    logic [CMD_INDEX_W-1:0] cmd_index_out;
    logic                   cmd_start;
    logic                   cmd_done;
    logic                   cmd_crc_err;
    logic                   dat_busy;
    logic                   dat_done;
    logic                   resp_enable;
    logic                   resp_ack;
    logic                   cc_enable;
    logic                   cc_ack;
    logic                   err_enable;
    logic                   err_ack;
    logic                   err_timeout;
    logic                   err_crc;
    logic                   inhibit_cmd;
    logic                   inhibit_dat;
    logic                   cmd_dropped;

    modport master (
        input  cmd_write, cmd_index_in, resp_type_in, data_present_in, timeout_enable,
        input  cmd_done, cmd_crc_err, dat_busy, dat_done, resp_ack, cc_ack, err_ack,
        output cmd_index_out, cmd_start, resp_enable, cc_enable, err_enable,
        output err_timeout, err_crc, inhibit_cmd, inhibit_dat, cmd_dropped
    );

    modport slave (
        output cmd_write, cmd_index_in, resp_type_in, data_present_in, timeout_enable,
        output cmd_done, cmd_crc_err, dat_busy, dat_done, resp_ack, cc_ack, err_ack,
        input  cmd_index_out, cmd_start, resp_enable, cc_enable, err_enable,
        input  err_timeout, err_crc, inhibit_cmd, inhibit_dat, cmd_dropped
    );

endinterface

// File: rtl/sd_timeout_counter.sv
// Loadable down-counter that saturates at zero; zero_c flags an expired timeout.
module sd_timeout_counter #(
    parameter int unsigned CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero_c
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign zero_c = (count_q == '0);

endmodule

// File: rtl/sd_cmd_sequencer.sv
// Sequences one SD command: accept the Command register write, pulse the CMD
// engine, time the response, then hand off to Response / Command Complete / error.
module sd_cmd_sequencer
    import sd_host_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = DEFAULT_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    sd_cmd_sequencer_if.master bus
);

    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES);

    seq_state_e state_q, state_d;
    cmd_req_t   req_q, new_req_c;
    logic       inhibit_cmd_q, inhibit_cmd_d;
    logic       inhibit_dat_q, inhibit_dat_d;
    logic       err_timeout_q, err_timeout_d;
    logic       err_crc_q, err_crc_d;
    logic       cmd_start_q, resp_enable_q, cc_enable_q, err_enable_q, cmd_dropped_q;
    logic       accept_c, timeout_c, cnt_load_c, cnt_dec_c, cnt_zero_c;

    assign new_req_c = {bus.cmd_index_in, bus.resp_type_in, bus.data_present_in};
    assign accept_c  = bus.cmd_write && !inhibit_cmd_q && (state_q == IDLE);
    assign timeout_c = cnt_zero_c && bus.timeout_enable;

    sd_timeout_counter #(.CNT_W(CNT_W)) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load_c),
        .dec      (cnt_dec_c),
        .load_val (TIMEOUT_LOAD),
        .zero_c   (cnt_zero_c)
    );

    // Next state, inhibit flags and error flags; a same-cycle inhibit set beats dat_done.
    always_comb begin
        state_d       = state_q;
        inhibit_cmd_d = inhibit_cmd_q;
        inhibit_dat_d = inhibit_dat_q;
        err_timeout_d = err_timeout_q;
        err_crc_d     = err_crc_q;
        cnt_load_c    = 1'b0;
        cnt_dec_c     = (state_q == WAIT_RESP) || (state_q == WAIT_BUSY);

        if (bus.dat_done) inhibit_dat_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d       = ISSUE;
                    inhibit_cmd_d = 1'b1;
                    if (bus.data_present_in || (bus.resp_type_in == RESP_48B))
                        inhibit_dat_d = 1'b1;
                end
            end
            ISSUE: begin
                cnt_load_c = 1'b1;
                state_d    = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (bus.cmd_done) begin
                    if (bus.cmd_crc_err) begin
                        state_d   = ERROR;
                        err_crc_d = 1'b1;
                    end else if (resp_expected(req_q.resp_type)) begin
                        state_d = STORE_RESP;
                    end else begin
                        state_d = SIGNAL;
                    end
                end else if (timeout_c) begin
                    state_d       = ERROR;
                    err_timeout_d = 1'b1;
                end
            end
            STORE_RESP: begin
                if (bus.resp_ack) begin
                    if (req_q.resp_type == RESP_48B) begin
                        cnt_load_c = 1'b1;
                        state_d    = WAIT_BUSY;
                    end else begin
                        state_d = SIGNAL;
                    end
                end
            end
            WAIT_BUSY: begin
                if (!bus.dat_busy) begin
                    state_d = SIGNAL;
                end else if (timeout_c) begin
                    state_d       = ERROR;
                    err_timeout_d = 1'b1;
                end
            end
            SIGNAL: begin
                if (bus.cc_ack) begin
                    state_d       = IDLE;
                    inhibit_cmd_d = 1'b0;
                    if (!req_q.data_present) inhibit_dat_d = 1'b0;
                end
            end
            ERROR: begin
                if (bus.err_ack) begin
                    state_d       = IDLE;
                    inhibit_cmd_d = 1'b0;
                    inhibit_dat_d = 1'b0;
                    err_timeout_d = 1'b0;
                    err_crc_d     = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Every output is a flop loaded from the next-state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            req_q         <= '0;
            inhibit_cmd_q <= 1'b0;
            inhibit_dat_q <= 1'b0;
            err_timeout_q <= 1'b0;
            err_crc_q     <= 1'b0;
            cmd_start_q   <= 1'b0;
            resp_enable_q <= 1'b0;
            cc_enable_q   <= 1'b0;
            err_enable_q  <= 1'b0;
            cmd_dropped_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            if (accept_c) req_q <= new_req_c;
            inhibit_cmd_q <= inhibit_cmd_d;
            inhibit_dat_q <= inhibit_dat_d;
            err_timeout_q <= err_timeout_d;
            err_crc_q     <= err_crc_d;
            cmd_start_q   <= (state_d == ISSUE);
            resp_enable_q <= (state_d == STORE_RESP);
            cc_enable_q   <= (state_d == SIGNAL);
            err_enable_q  <= (state_d == ERROR);
            cmd_dropped_q <= bus.cmd_write && inhibit_cmd_q;
        end
    end

    assign bus.cmd_index_out = req_q.index;
    assign bus.cmd_start     = cmd_start_q;
    assign bus.resp_enable   = resp_enable_q;
    assign bus.cc_enable     = cc_enable_q;
    assign bus.err_enable    = err_enable_q;
    assign bus.err_timeout   = err_timeout_q;
    assign bus.err_crc       = err_crc_q;
    assign bus.inhibit_cmd   = inhibit_cmd_q;
    assign bus.inhibit_dat   = inhibit_dat_q;
    assign bus.cmd_dropped   = cmd_dropped_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Directed bench for sd_cmd_sequencer: a table of whole transactions with
// hand-computed cycle counts, plus hand sequences for the multi-cycle corners.
module tb_sd_cmd_sequencer;

    localparam int unsigned T_CYC   = 16;
    localparam int unsigned T_CNT_W = 5;
    localparam int          LIMIT   = 60;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    sd_cmd_sequencer_if bus ();

    sd_cmd_sequencer #(.TIMEOUT_CYCLES(T_CYC), .CNT_W(T_CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // exp_idle: cycle (1 = ISSUE cycle) in which inhibit_cmd is first seen low again.
    typedef struct {
        string      name;
        logic [1:0] rt;
        logic [5:0] idx;
        logic       dp;
        logic       crc;
        int         d;
        logic       exp_inh_dat;
        int         exp_resp;
        int         exp_cc;
        int         exp_err;
        logic       exp_crc;
        logic       exp_to;
        int         exp_idle;
        logic       exp_inh_dat_end;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [14:0] outs();
        return {bus.cmd_index_out, bus.cmd_start, bus.resp_enable, bus.cc_enable,
                bus.err_enable, bus.err_timeout, bus.err_crc, bus.inhibit_cmd,
                bus.inhibit_dat, bus.cmd_dropped};
    endfunction

    task automatic issue(input logic [1:0] rt, input logic [5:0] idx, input logic dp);
        bus.resp_type_in    = rt;
        bus.cmd_index_in    = idx;
        bus.data_present_in = dp;
        bus.cmd_write       = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int   n_start, n_resp, n_cc, n_err, idle_c;
        logic seen_crc, seen_to;
        n_start = 0; n_resp = 0; n_cc = 0; n_err = 0; idle_c = -1;
        seen_crc = 1'b0; seen_to = 1'b0;
        issue(v.rt, v.idx, v.dp);
        for (int c = 1; c <= LIMIT; c++) begin
            @(negedge clk);
            bus.cmd_write = 1'b0;
            if (c == 1) begin
                check({v.name, " start"}, 32'(bus.cmd_start), 1);
                check({v.name, " inh_cmd"}, 32'(bus.inhibit_cmd), 1);
                check({v.name, " inh_dat"}, 32'(bus.inhibit_dat), 32'(v.exp_inh_dat));
                check({v.name, " index"}, 32'(bus.cmd_index_out), 32'(v.idx));
            end
            n_start += int'(bus.cmd_start);
            n_resp  += int'(bus.resp_enable);
            n_cc    += int'(bus.cc_enable);
            n_err   += int'(bus.err_enable);
            seen_crc = seen_crc | bus.err_crc;
            seen_to  = seen_to | bus.err_timeout;
            if (c > 1 && !bus.inhibit_cmd) begin
                idle_c = c;
                break;
            end
            bus.cmd_done    = (v.d >= 0) && (c == v.d + 2);
            bus.cmd_crc_err = bus.cmd_done && v.crc;
        end
        bus.cmd_done    = 1'b0;
        bus.cmd_crc_err = 1'b0;
        check({v.name, " n_start"}, n_start, 1);
        check({v.name, " n_resp"}, n_resp, v.exp_resp);
        check({v.name, " n_cc"}, n_cc, v.exp_cc);
        check({v.name, " n_err"}, n_err, v.exp_err);
        check({v.name, " err_crc"}, 32'(seen_crc), 32'(v.exp_crc));
        check({v.name, " err_to"}, 32'(seen_to), 32'(v.exp_to));
        check({v.name, " idle_cycle"}, idle_c, v.exp_idle);
        check({v.name, " inh_dat_end"}, 32'(bus.inhibit_dat), 32'(v.exp_inh_dat_end));
        bus.dat_done = 1'b1;
        @(negedge clk);
        bus.dat_done = 1'b0;
        check({v.name, " dat_done_clr"}, 32'(bus.inhibit_dat), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int   n_start;
        logic bad, held;

        //            name        rt     idx    dp    crc   d  inhd  rs cc er crc   to    idle endd
        vecs[0] = '{"r48_idx17", 2'b10, 6'd17, 1'b0, 1'b0,  5, 1'b0, 1, 1, 0, 1'b0, 1'b0, 10, 1'b0};
        vecs[1] = '{"none_fast", 2'b00, 6'd0,  1'b0, 1'b0,  0, 1'b0, 0, 1, 0, 1'b0, 1'b0,  4, 1'b0};
        vecs[2] = '{"r136_dp",   2'b01, 6'd2,  1'b1, 1'b0,  0, 1'b1, 1, 1, 0, 1'b0, 1'b0,  5, 1'b1};
        vecs[3] = '{"r48b_free", 2'b11, 6'd7,  1'b0, 1'b0,  2, 1'b1, 1, 1, 0, 1'b0, 1'b0,  8, 1'b0};
        vecs[4] = '{"crc_err",   2'b10, 6'd63, 1'b0, 1'b1,  3, 1'b0, 0, 0, 1, 1'b1, 1'b0,  7, 1'b0};
        vecs[5] = '{"timeout",   2'b10, 6'd33, 1'b1, 1'b0, -1, 1'b1, 0, 0, 1, 1'b0, 1'b1, 20, 1'b0};
        vecs[6] = '{"done_at_to",2'b00, 6'd9,  1'b0, 1'b0, 16, 1'b0, 0, 1, 0, 1'b0, 1'b0, 20, 1'b0};
        vecs[7] = '{"crc_dp",    2'b00, 6'd44, 1'b1, 1'b1,  0, 1'b1, 0, 0, 1, 1'b1, 1'b0,  4, 1'b0};

        rst_n = 1'b0;
        bus.cmd_write = 1'b0; bus.cmd_index_in = '0; bus.resp_type_in = '0;
        bus.data_present_in = 1'b0; bus.timeout_enable = 1'b1;
        bus.cmd_done = 1'b0; bus.cmd_crc_err = 1'b0; bus.dat_busy = 1'b0; bus.dat_done = 1'b0;
        bus.resp_ack = 1'b1; bus.cc_ack = 1'b1; bus.err_ack = 1'b1;

        repeat (2) @(negedge clk);
        check("reset_outs", 32'(outs()), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_outs", 32'(outs()), 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Busy held for 20 WAIT_BUSY cycles with timeout detection off.
        bus.timeout_enable = 1'b0; bus.dat_busy = 1'b1; bad = 1'b0;
        issue(2'b11, 6'd12, 1'b0);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            bus.cmd_write = 1'b0;
            if (c == 3) check("busy resp_en", 32'(bus.resp_enable), 1);
            if (c >= 4 && c <= 24) bad = bad | bus.cc_enable | !bus.inhibit_dat;
            if (c == 25) begin
                check("busy cc_after_fall", 32'(bus.cc_enable), 1);
                check("busy early_cc_or_dat_clr", 32'(bad), 0);
            end
            if (c == 26) begin
                check("busy inh_cmd_end", 32'(bus.inhibit_cmd), 0);
                check("busy inh_dat_end", 32'(bus.inhibit_dat), 0);
                break;
            end
            bus.cmd_done = (c == 2);
            bus.dat_busy = (c < 24);
        end
        bus.timeout_enable = 1'b1; bus.dat_busy = 1'b0; bus.cmd_done = 1'b0;

        // Write dropped during WAIT_RESP, then cc_ack held off for three cycles.
        bus.cc_ack = 1'b0; n_start = 0; held = 1'b1;
        issue(2'b10, 6'd5, 1'b0);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            bus.cmd_write = 1'b0;
            n_start += int'(bus.cmd_start);
            if (c == 4) check("drop pulse", 32'(bus.cmd_dropped), 1);
            if (c == 5) begin
                check("drop one_cycle", 32'(bus.cmd_dropped), 0);
                check("drop index_kept", 32'(bus.cmd_index_out), 5);
            end
            if (c >= 8 && c <= 10) held = held & bus.cc_enable;
            if (c == 11) begin
                check("cc held_until_ack", 32'(held), 1);
                check("cc drop_after_ack", 32'(bus.cc_enable), 0);
                check("cc inh_cmd_clr", 32'(bus.inhibit_cmd), 0);
            end
            if (c == 3) issue(2'b00, 6'd40, 1'b0);
            bus.cmd_done = (c == 6);
            bus.cc_ack   = (c >= 10);
        end
        check("drop single_start", n_start, 1);
        bus.cc_ack = 1'b1; bus.cmd_done = 1'b0;

        // Same-cycle inhibit_dat set beats dat_done; later dat_done clears it mid-transaction.
        issue(2'b10, 6'd3, 1'b1);
        bus.dat_done = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            bus.cmd_write = 1'b0;
            if (c == 1) check("setwin inh_dat", 32'(bus.inhibit_dat), 1);
            if (c == 4) check("setwin mid_clr", 32'(bus.inhibit_dat), 0);
            if (c == 5) check("setwin inh_cmd_end", 32'(bus.inhibit_cmd), 0);
            bus.cmd_done = (c == 2);
            bus.dat_done = (c == 3);
        end
        bus.cmd_done = 1'b0; bus.dat_done = 1'b0;

        // Asynchronous reset while STORE_RESP waits on a low resp_ack.
        bus.resp_ack = 1'b0;
        issue(2'b10, 6'd21, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            bus.cmd_write = 1'b0;
            bus.cmd_done  = (c == 2);
        end
        check("store resp_en_held", 32'(bus.resp_enable), 1);
        #2 rst_n = 1'b0;
        #1 check("async_reset outs", 32'(outs()), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1; bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bad = bad | (outs() != '0);
        end
        check("after_reset quiet", 32'(bad), 0);
        bus.resp_ack = 1'b1;

        run_vec(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_cmd_sequencer.md
# sd_cmd_sequencer

Sequences a single SD command transaction between the host register file and the CMD line engine. Accepts a CPU write of the Command register (00Eh), drives the Present State (024h) inhibit bits, and issues the start pulse to the CMD engine. Runs the response timeout, hands the response to the Response register (010h), and raises Command Complete (030h bit 0) or error status (032h) through enable/ack handshakes. Sits in the SD host top, between the register blocks and the CMD engine.

## Interface
- TIMEOUT_CYCLES, 1024: clock cycles allowed in WAIT_RESP and in WAIT_BUSY before a timeout.
- CNT_W, 11: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.
- clock  in  1  system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_write  in  1  one-cycle pulse when the CPU writes 00Eh.
- cmd_index_in  in  6  00Eh[13:8].
- resp_type_in  in  2  00Eh[1:0]: 00 none, 01 136-bit, 10 48-bit, 11 48-bit with busy.
- data_present_in  in  1  00Eh[5].
- timeout_enable  in  1  032h-derived enable for timeout detection.
- cmd_index_out  out  6  latched index, presented to the CMD engine.
- cmd_start  out  1  one-cycle start pulse to the CMD engine (new_command).
- cmd_done  in  1  CMD engine command_complete pulse.
- cmd_crc_err  in  1  CRC-error qualifier for cmd_done; valid only while cmd_done is high.
- dat_busy  in  1  DAT0 busy level (024h[2]).
- dat_done  in  1  pulse from the data path when a data transfer ends.
- resp_enable / resp_ack  out / in  1  handshake to the Response register.
- cc_enable / cc_ack  out / in  1  handshake to the 030h Command Complete bit.
- err_enable / err_ack  out / in  1  handshake to 032h.
- err_timeout, err_crc  out  1  error flags; valid while err_enable is high.
- inhibit_cmd, inhibit_dat  out  1  024h[0] and 024h[1].
- cmd_dropped  out  1  one-cycle pulse when cmd_write arrives while inhibit_cmd=1.

## Operation
- States: IDLE, ISSUE, WAIT_RESP, STORE_RESP, WAIT_BUSY, SIGNAL, ERROR. All outputs are Moore outputs, decoded from registered state/flags.
- IDLE + cmd_write with inhibit_cmd=0:
  - latch index, resp_type and data_present;
  - set inhibit_cmd; set inhibit_dat if data_present=1 or resp_type=11;
  - go to ISSUE.
- Any cmd_write while inhibit_cmd=1 is ignored and pulses cmd_dropped.
- ISSUE: cmd_start=1 for one cycle; load counter with TIMEOUT_CYCLES; go to WAIT_RESP.
- WAIT_RESP: counter decrements each cycle, saturating at 0.
  - cmd_done with cmd_crc_err=1 → ERROR, err_crc=1.
  - cmd_done with cmd_crc_err=0 → SIGNAL if resp_type=00, else STORE_RESP.
  - counter=0 with timeout_enable=1 and no cmd_done → ERROR, err_timeout=1.
  - cmd_done and timeout in the same cycle: cmd_done wins.
- STORE_RESP: hold resp_enable=1 until resp_ack is sampled high. Then go to WAIT_BUSY if resp_type=11 (reload counter), else SIGNAL.
- WAIT_BUSY: go to SIGNAL when dat_busy=0 is sampled. Timeout, gated by timeout_enable, goes to ERROR with err_timeout=1.
- SIGNAL: hold cc_enable=1 until cc_ack. On the ack cycle:
  - clear inhibit_cmd;
  - clear inhibit_dat if the latched data_present=0;
  - go to IDLE.
- ERROR: hold err_enable and the flag until err_ack. On the ack cycle clear both inhibits, clear the flags, go to IDLE.
- dat_done clears inhibit_dat in any state. If dat_done and the set condition occur in the same cycle, the set wins.
- Reset, asynchronous and at any point including mid-transaction:
  - state=IDLE; all outputs 0; counter 0; latches 0.
  - No cmd_start is emitted after reset release until a new cmd_write.

## Timing
- cmd_write sampled at edge N → inhibit_cmd=1 and cmd_start=1 during cycle N+1. cmd_start is exactly one cycle wide.
- The timeout fires TIMEOUT_CYCLES cycles after the first WAIT_RESP cycle.
- Handshakes are level-held: an enable stays high from state entry through the cycle ack is sampled and drops the next cycle. An ack already high on entry completes the handshake in one cycle.
- Best case, resp_type=00 with cmd_done in the first WAIT_RESP cycle and immediate cc_ack: IDLE is reached 4 cycles after cmd_write.

## Structure
- Shared package sd_host_pkg holds:
  - the FSM state enum;
  - response-type constants RESP_NONE, RESP_136, RESP_48, RESP_48B;
  - the default TIMEOUT_CYCLES.
- One sub-module, sd_timeout_counter, with load, decrement and zero-flag behaviour, instantiated once and reloaded on entry to WAIT_RESP and WAIT_BUSY.

## Test plan
- resp_type=10, index 17; cmd_done after 5 cycles; resp_ack and cc_ack tied high → cmd_start one cycle at N+1, resp_enable one cycle, cc_enable one cycle, inhibit_cmd 1→0, err flags 0.
- resp_type=11; dat_busy held high for 20 cycles after the response → SIGNAL only after dat_busy falls; inhibit_dat stays 1 until then.
- TIMEOUT_CYCLES=16, timeout_enable=1, no cmd_done → err_enable with err_timeout=1 at WAIT_RESP cycle 16; after err_ack both inhibits are 0 and state is IDLE.
- cmd_done with cmd_crc_err=1 → err_crc=1, no resp_enable, no cc_enable.
- Second cmd_write while in WAIT_RESP → cmd_dropped pulse, no second cmd_start, latched index unchanged.
- Reset asserted during STORE_RESP with resp_ack held low → all outputs 0 immediately; after release, no activity until the next cmd_write.
